// File: rtl/qspi_arb_pkg.sv
// Shared types and constants for the QSPI bus arbiter.
package qspi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ACTIVE,
        STOP,
        GAP
    } arb_state_t;

    localparam logic [1:0] TGT_FLASH   = 2'd0;
    localparam logic [1:0] TGT_RAM_A   = 2'd1;
    localparam logic [1:0] TGT_RAM_B   = 2'd2;
    localparam logic [1:0] TGT_INVALID = 2'd3;

    // A request is only eligible for the bus when it names a real target.
    function automatic logic sel_valid(input logic [1:0] sel);
        return sel != TGT_INVALID;
    endfunction

endpackage

// File: rtl/qspi_arb_sat_counter.sv
// Saturating up-counter with synchronous clear and a terminal flag
// (terminal = count has reached LIMIT). Never wraps.
module qspi_arb_sat_counter #(
    parameter int WIDTH = 5,
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic terminal
);

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count_reg;

    // Count up while inc is held, stick at LIMIT, clear on request.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg < LIMIT_V)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign terminal = (count_reg >= LIMIT_V);

endmodule

// File: rtl/qspi_bus_arbiter.sv
// Two-requester arbiter for the shared QSPI pins / spi_flash_controller.
// Requester 0 (video stream) has priority and may preempt requester 1 at a
// word boundary after waiting PREEMPT_WAIT cycles. Each transaction is
// followed by CS_GAP cycles with every chip select high.
// Build option: define QSPI_ARB_ROUND_ROBIN_EN to alternate grants between
// the two requesters instead (preemption is then disabled).
module qspi_bus_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int ADDR_BITS    = 24,
    parameter int PREEMPT_WAIT = 16,
    parameter int CS_GAP       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [ADDR_BITS-1:0] addr0,
    input  logic [1:0]           sel0,
    input  logic                 next0,
    input  logic                 done0,
    output logic                 grant0,
    output logic                 ready0,
    input  logic                 req1,
    input  logic [ADDR_BITS-1:0] addr1,
    input  logic [1:0]           sel1,
    input  logic                 next1,
    input  logic                 done1,
    output logic                 grant1,
    output logic                 ready1,
    output logic                 preempted1,
    output logic                 ctl_start,
    output logic                 ctl_continue,
    output logic                 ctl_stop,
    output logic [ADDR_BITS-1:0] ctl_addr,
    input  logic                 ctl_busy,
    input  logic                 ctl_select,
    output logic [2:0]           cs_n
);

    localparam int WAIT_W    = $clog2(PREEMPT_WAIT + 1);
    localparam int GAP_W     = 4;
    localparam int GAP_LIMIT = CS_GAP - 1;

    arb_state_t state_reg, state_next;

    logic                 grant0_reg, grant0_next;
    logic                 grant1_reg, grant1_next;
    logic                 start_reg, start_next;
    logic                 cont_reg, cont_next;
    logic                 stop_reg, stop_next;
    logic                 pre_reg, pre_next;
    logic [ADDR_BITS-1:0] addr_reg, addr_next;
    logic [1:0]           cur_sel_reg, cur_sel_next;
    logic [2:0]           cs_n_reg, cs_n_next;

    logic win0, win1, pick0, pick1, prefer0;
    logic engaged;
    logic wait_inc, wait_terminal, gap_terminal;
    logic preempt_en, preempt_hit;
    logic end0, end1, preempt_now;

    assign win0 = req0 && sel_valid(sel0);
    assign win1 = req1 && sel_valid(sel1);

`ifdef QSPI_ARB_ROUND_ROBIN_EN
    logic last_winner_reg;

    // Remember who was granted last so the other side wins a tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner_reg <= 1'b1;
        end else if (pick0) begin
            last_winner_reg <= 1'b0;
        end else if (pick1) begin
            last_winner_reg <= 1'b1;
        end
    end

    assign prefer0    = last_winner_reg;
    assign preempt_en = 1'b0;
`else
    assign prefer0    = 1'b1;
    assign preempt_en = 1'b1;
`endif

    // Winner selection is only acted upon in IDLE.
    assign pick0 = (state_reg == IDLE) && win0 && (!win1 || prefer0);
    assign pick1 = (state_reg == IDLE) && win1 && !pick0;

    // A word is available only once the controller has settled after the
    // last start/continue pulse.
    assign ready0 = grant0_reg && (state_reg == ACTIVE) && !ctl_busy && !start_reg && !cont_reg;
    assign ready1 = grant1_reg && (state_reg == ACTIVE) && !ctl_busy && !start_reg && !cont_reg;

    // Preempt wait: counts while a valid req0 is pending under grant1.
    assign wait_inc = preempt_en && grant1_reg && win0;

    qspi_arb_sat_counter #(
        .WIDTH (WAIT_W),
        .LIMIT (PREEMPT_WAIT)
    ) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (!wait_inc),
        .inc      (wait_inc),
        .terminal (wait_terminal)
    );

    // Gap timer: counts cycles spent in GAP, idle otherwise.
    qspi_arb_sat_counter #(
        .WIDTH (GAP_W),
        .LIMIT (GAP_LIMIT)
    ) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_reg != GAP),
        .inc      (state_reg == GAP),
        .terminal (gap_terminal)
    );

    assign preempt_hit = preempt_en && wait_terminal;
    assign end0        = done0 || !req0;
    assign end1        = done1 || !req1;
    assign preempt_now = preempt_hit && ready1;

    // Next-state and pulse generation for the arbitration FSM.
    always_comb begin
        state_next   = state_reg;
        grant0_next  = grant0_reg;
        grant1_next  = grant1_reg;
        start_next   = 1'b0;
        cont_next    = 1'b0;
        stop_next    = 1'b0;
        pre_next     = 1'b0;
        addr_next    = addr_reg;
        cur_sel_next = cur_sel_reg;

        unique case (state_reg)
            IDLE: begin
                if (pick0) begin
                    addr_next    = addr0;
                    cur_sel_next = sel0;
                    grant0_next  = 1'b1;
                    state_next   = START;
                end else if (pick1) begin
                    addr_next    = addr1;
                    cur_sel_next = sel1;
                    grant1_next  = 1'b1;
                    state_next   = START;
                end
            end
            START: begin
                start_next = 1'b1;
                state_next = ACTIVE;
            end
            ACTIVE: begin
                if (grant0_reg) begin
                    if (end0) begin
                        stop_next   = 1'b1;
                        grant0_next = 1'b0;
                        state_next  = STOP;
                    end else if (next0 && ready0) begin
                        cont_next = 1'b1;
                    end
                end else if (grant1_reg) begin
                    if (end1 || preempt_now) begin
                        stop_next   = 1'b1;
                        pre_next    = !end1;
                        grant1_next = 1'b0;
                        state_next  = STOP;
                    end else if (next1 && ready1) begin
                        cont_next = 1'b1;
                    end
                end else begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (!ctl_busy) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (gap_terminal) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Route the controller select to the current target only while engaged.
    assign engaged = (state_reg == START) || (state_reg == ACTIVE) || (state_reg == STOP);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cs
            assign cs_n_next[gi] = (engaged && (cur_sel_reg == 2'(gi))) ? ctl_select : 1'b1;
        end
    endgenerate

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            grant0_reg  <= 1'b0;
            grant1_reg  <= 1'b0;
            start_reg   <= 1'b0;
            cont_reg    <= 1'b0;
            stop_reg    <= 1'b0;
            pre_reg     <= 1'b0;
            addr_reg    <= '0;
            cur_sel_reg <= TGT_FLASH;
            cs_n_reg    <= 3'b111;
        end else begin
            state_reg   <= state_next;
            grant0_reg  <= grant0_next;
            grant1_reg  <= grant1_next;
            start_reg   <= start_next;
            cont_reg    <= cont_next;
            stop_reg    <= stop_next;
            pre_reg     <= pre_next;
            addr_reg    <= addr_next;
            cur_sel_reg <= cur_sel_next;
            cs_n_reg    <= cs_n_next;
        end
    end

    assign grant0       = grant0_reg;
    assign grant1       = grant1_reg;
    assign ctl_start    = start_reg;
    assign ctl_continue = cont_reg;
    assign ctl_stop     = stop_reg;
    assign preempted1   = pre_reg;
    assign ctl_addr     = addr_reg;
    assign cs_n         = cs_n_reg;

endmodule
